// File: rtl/lvc_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lvc_ahb_arbiter
// Brief    : Registered round-robin AHB arbiter with burst/lock protection and
//            default-master parking.
// Revision : 1.0
// ============================================================================
module lvc_ahb_arbiter #(
    parameter int NUM_MST     = 4,
    parameter int DEFAULT_MST = 0,
    parameter int MW          = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    input  logic [1:0]         hresp,
    output logic [NUM_MST-1:0] hgrant,
    output logic [MW-1:0]      hmaster,
    output logic               hmastlock
);

    localparam logic [1:0]         C_TRANS_NONSEQ = 2'd2;
    localparam logic [1:0]         C_TRANS_SEQ    = 2'd3;
    localparam logic [1:0]         C_RESP_OKAY    = 2'd0;
    localparam logic [MW-1:0]      C_DEF_IDX      = MW'(DEFAULT_MST);
    localparam logic [NUM_MST-1:0] C_DEF_GRANT    = NUM_MST'(1) << DEFAULT_MST;

    logic [NUM_MST-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0]      hmaster_q, hmaster_d;
    logic               hmastlock_q, hmastlock_d;
    logic [MW-1:0]      last_q, last_d;
    logic [4:0]         rem_q, rem_d;

    logic [4:0]         burst_len;
    logic [MW-1:0]      grant_idx;
    logic [MW-1:0]      winner;
    logic               found;
    logic               locked;
    logic               arb_en;

    always_comb begin
        case (hburst)
            3'd0:       burst_len = 5'd1;
            3'd1:       burst_len = 5'd0;
            3'd2, 3'd3: burst_len = 5'd4;
            3'd4, 3'd5: burst_len = 5'd8;
            default:    burst_len = 5'd16;
        endcase
    end

    // Beat counter: an error-class response cuts the burst short
    always_comb begin
        rem_d = rem_q;
        if (hready) begin
            if (hresp != C_RESP_OKAY)
                rem_d = 5'd0;
            else if (htrans == C_TRANS_NONSEQ && burst_len != 5'd0)
                rem_d = burst_len - 5'd1;
            else if (htrans == C_TRANS_SEQ && rem_q != 5'd0)
                rem_d = rem_q - 5'd1;
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MST; i++)
            if (hgrant_q[i]) grant_idx = MW'(i);
    end

    always_comb begin
        int          cand;
        logic [MW-1:0] cand_idx;
        found  = 1'b0;
        winner = last_q;
        for (int k = 1; k <= NUM_MST; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_MST) cand = cand - NUM_MST;
            cand_idx = MW'(cand);
            if (!found && hbusreq[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    assign locked = hlock[grant_idx];
    assign arb_en = hready && (rem_d <= 5'd1) && !locked;

    always_comb begin
        hgrant_d    = hgrant_q;
        last_d      = last_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (arb_en) begin
            if (found) begin
                hgrant_d         = '0;
                hgrant_d[winner] = 1'b1;
                last_d           = winner;
            end else begin
                hgrant_d = C_DEF_GRANT;
            end
        end
        // Ownership follows the grant that was already on the bus this cycle
        if (hready) begin
            hmaster_d   = grant_idx;
            hmastlock_d = hlock[grant_idx];
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant_q    <= C_DEF_GRANT;
            hmaster_q   <= C_DEF_IDX;
            hmastlock_q <= 1'b0;
            last_q      <= C_DEF_IDX;
            rem_q       <= 5'd0;
        end else begin
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            last_q      <= last_d;
            rem_q       <= rem_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule
`default_nettype wire

// File: tb/tb_lvc_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvc_ahb_arbiter
// Brief    : Directed scoreboard bench for lvc_ahb_arbiter (4 masters).
// Revision : 1.0
// ============================================================================
module tb_lvc_ahb_arbiter;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NS   = 2'd2;
    localparam logic [1:0] SQ   = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] WRAP16 = 3'd6;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    lvc_ahb_arbiter #(
        .NUM_MST     (4),
        .DEFAULT_MST (0),
        .MW          (2)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [1:0] rsp, input logic [3:0] eg, input logic [1:0] em,
                       input logic el);
        exp_t e;
        hbusreq = req;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        hresp   = rsp;
        e.g = eg; e.m = em; e.l = el; e.tag = tag;
        exp_q.push_back(e);
        @(negedge hclk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge hclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (hgrant !== e.g || hmaster !== e.m || hmastlock !== e.l || !$onehot(hgrant)) begin
                    errors++;
                    $display("FAIL %s: got grant=%b master=%0d lock=%b, expected grant=%b master=%0d lock=%b",
                             e.tag, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        hresetn = 1'b0;
        hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1; hresp = 2'd0;
        @(negedge hclk);

        // Reset and parking
        cyc("rst_a", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);
        cyc("rst_b", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);
        hresetn = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc("park", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);

        // Round-robin among 1, 2, 3
        cyc("rr1",   4'b1110, 4'b0000, NS,   SINGLE, 1, 0, 4'b0010, 2'd0, 0);
        cyc("rr2",   4'b1110, 4'b0000, NS,   SINGLE, 1, 0, 4'b0100, 2'd1, 0);
        cyc("rr3",   4'b1110, 4'b0000, NS,   SINGLE, 1, 0, 4'b1000, 2'd2, 0);
        cyc("rr4",   4'b1110, 4'b0000, NS,   SINGLE, 1, 0, 4'b0010, 2'd3, 0);
        cyc("rr_i1", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd1, 0);
        cyc("rr_i2", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);

        // INCR8 from master 2 with master 1 waiting
        cyc("b_req", 4'b0100, 4'b0000, IDLE, INCR8, 1, 0, 4'b0100, 2'd0, 0);
        cyc("b_ns",  4'b0110, 4'b0000, NS,   INCR8, 1, 0, 4'b0100, 2'd2, 0);
        for (int i = 0; i < 5; i++)
            cyc("b_seq", 4'b0110, 4'b0000, SQ, INCR8, 1, 0, 4'b0100, 2'd2, 0);
        cyc("b_hand", 4'b0110, 4'b0000, SQ,   INCR8,  1, 0, 4'b0010, 2'd2, 0);
        cyc("b_last", 4'b0010, 4'b0000, SQ,   INCR8,  1, 0, 4'b0010, 2'd1, 0);
        cyc("b_i1",   4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd1, 0);
        cyc("b_i2",   4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);

        // INCR4 with a 3-cycle stall on the second beat
        cyc("w_req", 4'b0100, 4'b0000, IDLE, INCR4, 1, 0, 4'b0100, 2'd0, 0);
        cyc("w_ns",  4'b0110, 4'b0000, NS,   INCR4, 1, 0, 4'b0100, 2'd2, 0);
        for (int i = 0; i < 3; i++)
            cyc("w_wait", 4'b0110, 4'b0000, SQ, INCR4, 0, 0, 4'b0100, 2'd2, 0);
        cyc("w_s2",  4'b0110, 4'b0000, SQ,   INCR4,  1, 0, 4'b0100, 2'd2, 0);
        cyc("w_s3",  4'b0110, 4'b0000, SQ,   INCR4,  1, 0, 4'b0010, 2'd2, 0);
        cyc("w_s4",  4'b0010, 4'b0000, SQ,   INCR4,  1, 0, 4'b0010, 2'd1, 0);
        cyc("w_i1",  4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd1, 0);
        cyc("w_i2",  4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);

        // Locked master 3 with two INCR bursts while master 0 requests
        cyc("l_req",  4'b1000, 4'b1000, IDLE, INCR,   1, 0, 4'b1000, 2'd0, 0);
        cyc("l_ns1",  4'b1001, 4'b1000, NS,   INCR,   1, 0, 4'b1000, 2'd3, 1);
        cyc("l_sq1",  4'b1001, 4'b1000, SQ,   INCR,   1, 0, 4'b1000, 2'd3, 1);
        cyc("l_sq2",  4'b1001, 4'b1000, SQ,   INCR,   1, 0, 4'b1000, 2'd3, 1);
        cyc("l_ns2",  4'b1001, 4'b1000, NS,   INCR,   1, 0, 4'b1000, 2'd3, 1);
        cyc("l_sq3",  4'b1001, 4'b1000, SQ,   INCR,   1, 0, 4'b1000, 2'd3, 1);
        cyc("l_drop", 4'b1001, 4'b0000, IDLE, INCR,   1, 0, 4'b0001, 2'd3, 0);
        cyc("l_i1",   4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);

        // ERROR on second beat of WRAP16
        cyc("e_req", 4'b0010, 4'b0000, IDLE, WRAP16, 1, 0, 4'b0010, 2'd0, 0);
        cyc("e_ns",  4'b0110, 4'b0000, NS,   WRAP16, 1, 0, 4'b0010, 2'd1, 0);
        cyc("e_err", 4'b0110, 4'b0000, SQ,   WRAP16, 1, 1, 4'b0100, 2'd1, 0);
        cyc("e_i1",  4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd2, 0);
        cyc("e_i2",  4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);

        // Asynchronous reset in the middle of an INCR8
        cyc("r_req", 4'b0010, 4'b0000, IDLE, INCR8, 1, 0, 4'b0010, 2'd0, 0);
        cyc("r_ns",  4'b0110, 4'b0000, NS,   INCR8, 1, 0, 4'b0010, 2'd1, 0);
        cyc("r_s1",  4'b0110, 4'b0000, SQ,   INCR8, 1, 0, 4'b0010, 2'd1, 0);
        hresetn = 1'b0;
        #1;
        checks++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
            errors++;
            $display("FAIL r_async: got grant=%b master=%0d lock=%b, expected grant=0001 master=0 lock=0",
                     hgrant, hmaster, hmastlock);
        end
        cyc("r_hold", 4'b0110, 4'b0000, SQ,   INCR8,  1, 0, 4'b0001, 2'd0, 0);
        hresetn = 1'b1;
        cyc("r_rel",  4'b0100, 4'b0000, IDLE, INCR8,  1, 0, 4'b0100, 2'd0, 0);
        cyc("r_seq",  4'b0010, 4'b0000, SQ,   INCR8,  1, 0, 4'b0010, 2'd2, 0);
        cyc("r_i1",   4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd1, 0);
        cyc("r_i2",   4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 2'd0, 0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge hclk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never consumed, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lvc_ahb_arbiter.md
# lvc_ahb_arbiter

Registered multi-master AHB bus arbiter for the lvc_ahb environment. It samples per-master `hbusreq`/`hlock` and the shared address-phase controls. It drives one-hot `hgrant`, the address-bus owner index `hmaster`, and `hmastlock`. Fixed-length bursts and locked sequences are never split, and free slots are shared round-robin. Idle bus time is parked on a default master.

## Interface
- `NUM_MST`, 4, number of masters (2..16)
- `DEFAULT_MST`, 0, parking master index (< NUM_MST)
- `MW`, $clog2(NUM_MST), width of `hmaster`
- `hclk` in 1: bus clock; all state updates on rising edge
- `hresetn` in 1: reset; asynchronous assert, active-low
- `hbusreq` in NUM_MST: per-master bus request
- `hlock` in NUM_MST: per-master lock request
- `htrans` in 2: address-phase transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
- `hburst` in 3: 0 SINGLE, 1 INCR, 2/3 WRAP4/INCR4, 4/5 WRAP8/INCR8, 6/7 WRAP16/INCR16
- `hready` in 1: transfer done / phase advance
- `hresp` in 2: slave response (0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT)
- `hgrant` out NUM_MST: one-hot grant, registered
- `hmaster` out MW: current address-bus owner, registered
- `hmastlock` out 1: current address phase is locked, registered

## Operation
- Reset values:
  - `hgrant` = one-hot bit DEFAULT_MST.
  - `hmaster` = DEFAULT_MST.
  - `hmastlock` = 0.
  - Round-robin pointer `last` = DEFAULT_MST.
  - Beat counter `rem` = 0.
- Burst length L, taken from `hburst`: SINGLE=1, INCR=0 (undefined), ×4=4, ×8=8, ×16=16.
- `rem` is 5 bits. It is updated only on cycles with `hready`=1, in this order:
  - `hresp`≠OKAY: `rem`←0. This is an early termination.
  - `htrans`=NONSEQ and L≥1: `rem`←L−1.
  - `htrans`=SEQ and `rem`>0: `rem`←`rem`−1.
  - BUSY/IDLE: `rem` holds.
- `rem_nxt` is the value `rem` takes at the coming edge.
- States, derived:
  - ARB when `rem_nxt`≤1.
  - BURST when `rem_nxt`≥2.
  - LOCKED when `hlock[g]`=1, where g = current grant index. LOCKED overrides ARB.
- Re-arbitration is enabled iff `hready`=1 and state=ARB and not LOCKED.
  - Consequence: a fixed burst loses grant only during its penultimate address phase.
  - Consequence: INCR and SINGLE transfers lose grant on any accepted phase.
- Arbitration rules:
  - Scan masters (`last`+1) mod NUM_MST upward and grant the first with `hbusreq`=1; `last`←winner.
  - If no request is set, grant DEFAULT_MST and leave `last` unchanged.
  - If the current owner still requests and is the scan winner, it keeps the grant.
- `hmaster`←index(`hgrant`) and `hmastlock`←`hlock[index(hgrant)]` on every edge with `hready`=1. Both hold while `hready`=0.
- `hgrant` is always exactly one-hot; an all-zero or multi-hot grant is a bug.
- Requests from masters ≥ NUM_MST do not exist. Unused encodings of `hmaster` never appear.

## Timing
- Request to grant: 1 cycle when arbitration is enabled. A request sampled at edge n gives `hgrant` at edge n.
- Grant to ownership: `hmaster` follows `hgrant` at the first later edge with `hready`=1. The minimum is 1 cycle.
- Wait states (`hready`=0) freeze `hgrant`, `hmaster`, `hmastlock`, `rem` and `last`.
- Simultaneous requests: the round-robin order decides. No master waits more than NUM_MST−1 arbitration opportunities while others are unlocked.
- Error/RETRY/SPLIT with `hready`=1: `rem` is cleared, and arbitration is enabled in the same cycle unless the master is locked.
- Reset mid-burst: all state returns to reset values immediately, asynchronously. The first grant decision is at the first edge after release.

## Test plan
- Reset/park: reset, no requests for 10 cycles -> `hgrant`=0001, `hmaster`=0, `hmastlock`=0 throughout.
- Round-robin: masters 1, 2, 3 all requesting, SINGLE NONSEQ each cycle, `hready`=1 -> grant order 1, 2, 3, 1, changing every cycle; `hmaster` lags `hgrant` by one cycle.
- Fixed burst protection: master 2 INCR8 while master 1 requests -> grant stays on 2 through SEQ beats 1–6 and moves to 1 at the edge ending beat 7 (`rem_nxt`=1). `hmaster`=1 starts after beat 8.
- Wait states: INCR4 with `hready`=0 for 3 cycles on beat 2 -> `rem`, `hgrant` and `hmaster` frozen; the handover still happens after beat 4.
- Lock: master 3 with `hlock`=1 runs two INCR bursts back-to-back while master 0 requests -> `hgrant` stays 1000 and `hmastlock`=1; the grant moves to 0 one cycle after `hlock[3]` drops.
- Early termination: ERROR response on beat 2 of WRAP16 -> `rem`=0 and the grant passes to the next requester at that edge.
